ex_complete_stage: RTL and testbench

- Registered completion stage directly downstream of the execute stage.
- Latches the execute stage's CDB winner each cycle and drives the PRF write port (ex_wb_result / ex_wb_PRF_num) plus the tag broadcast to the RS.
- Buffers branch and store completions in a small FIFO toward the ROB completion port, which may backpressure.
- Upstream issue stalls when the FIFO nears full; the ROB flush clears all in-flight state.

---
 rtl/ex_complete_stage_pkg.sv | 19 +
 rtl/ex_complete_stage_cmpl_fifo.sv | 66 ++++++
 rtl/ex_complete_stage.sv | 120 ++++++++++++
 tb/tb_ex_complete_stage.sv | 248 ++++++++++++++++++++++++
 4 files changed

// File: rtl/ex_complete_stage_pkg.sv
// Shared widths and the completion queue entry layout for the EX completion stage.
package ex_complete_stage_pkg;

    localparam int unsigned PRF_WIDTH    = 6;
    localparam int unsigned ROB_WIDTH    = 5;
    localparam int unsigned NPC_WIDTH    = 64;
    localparam int unsigned CQ_DEPTH_DEF = 4;
    localparam int unsigned NULL_PRF     = 0;

    typedef struct packed {
        logic [ROB_WIDTH-1:0] rob_num;
        logic                 branch;
        logic                 store;
        logic                 taken;
        logic                 mispredict;
        logic [NPC_WIDTH-1:0] npc;
    } cq_entry_t;

endpackage

// File: rtl/ex_complete_stage_cmpl_fifo.sv
// Synchronous FIFO of completion entries with flush; head is read combinationally.
module cmpl_fifo
    import ex_complete_stage_pkg::*;
#(
    parameter int unsigned DEPTH = CQ_DEPTH_DEF
) (
    input  logic                         i_clk,
    input  logic                         i_reset,
    input  logic                         i_push,
    input  logic                         i_pop,
    input  logic                         i_flush,
    input  cq_entry_t                    i_data,
    output cq_entry_t                    o_head,
    output logic [$clog2(DEPTH+1)-1:0]   o_count,
    output logic                         o_empty,
    output logic                         o_full
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = $clog2(DEPTH + 1);

    cq_entry_t        r_mem [DEPTH];
    logic [PTR_W-1:0] r_head;
    logic [PTR_W-1:0] r_tail;
    logic [CNT_W-1:0] r_count;

    logic w_pop;
    logic w_push;

    // A full queue still accepts a push when the head leaves in the same cycle.
    assign o_empty = (r_count == '0);
    assign o_full  = (r_count == CNT_W'(DEPTH));
    assign w_pop   = i_pop && !o_empty;
    assign w_push  = i_push && (!o_full || w_pop);
    assign o_head  = r_mem[r_head];
    assign o_count = r_count;

    // Pointer and occupancy update; flush empties the queue outright.
    always_ff @(posedge i_clk) begin
        if (i_reset || i_flush) begin
            r_head  <= '0;
            r_tail  <= '0;
            r_count <= '0;
        end else begin
            if (w_push) begin
                r_tail <= r_tail + PTR_W'(1);
            end
            if (w_pop) begin
                r_head <= r_head + PTR_W'(1);
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + CNT_W'(1);
                2'b01:   r_count <= r_count - CNT_W'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    // Entry storage; slots are only read while counted valid, so no reset is needed.
    always_ff @(posedge i_clk) begin
        if (w_push && !i_flush && !i_reset) begin
            r_mem[r_tail] <= i_data;
        end
    end

endmodule

// File: rtl/ex_complete_stage.sv
// Completion stage after EX: registers the CDB winner for PRF write / tag broadcast
// and queues branch and store completions toward the ROB.
module ex_complete_stage
    import ex_complete_stage_pkg::*;
#(
    parameter int unsigned PRF_W    = PRF_WIDTH,
    parameter int unsigned ROB_W    = ROB_WIDTH,
    parameter int unsigned CQ_DEPTH = CQ_DEPTH_DEF
) (
    input  logic              clock,
    input  logic              reset,
    input  logic [PRF_W-1:0]  ex_CDB_tag_in,
    input  logic [63:0]       ex_result_in,
    input  logic              ex_branch_inst_in,
    input  logic              ex_branch_taken_in,
    input  logic              ex_branch_mispredict_in,
    input  logic              ex_store_inst_in,
    input  logic [ROB_W-1:0]  ex_ROB_number_in,
    input  logic [63:0]       ex_NPC_in,
    input  logic              rob_flush_in,
    input  logic              rob_cmpl_ready_in,
    output logic [PRF_W-1:0]  ex_wb_PRF_num_out,
    output logic [63:0]       ex_wb_result_out,
    output logic              cdb_valid_out,
    output logic              cmpl_valid_out,
    output logic [ROB_W-1:0]  cmpl_ROB_num_out,
    output logic              cmpl_branch_out,
    output logic              cmpl_store_out,
    output logic              cmpl_taken_out,
    output logic              cmpl_mispredict_out,
    output logic [63:0]       cmpl_NPC_out,
    output logic              cq_stall_out,
    output logic              cq_overflow_out
);

    localparam int unsigned CNT_W = $clog2(CQ_DEPTH + 1);

    logic [PRF_W-1:0] r_tag;
    logic [63:0]      r_result;
    logic             r_overflow;

    cq_entry_t        w_entry;
    cq_entry_t        w_head;
    cq_entry_t        w_head_vis;
    logic [CNT_W-1:0] w_count;
    logic             w_empty;
    logic             w_full;
    logic             w_push;
    logic             w_pop;

    // Build the queue entry; a branch wins over a simultaneous store, stores carry no branch info.
    always_comb begin
        w_entry            = '0;
        w_entry.rob_num    = ROB_WIDTH'(ex_ROB_number_in);
        w_entry.branch     = ex_branch_inst_in;
        w_entry.store      = ex_store_inst_in && !ex_branch_inst_in;
        if (ex_branch_inst_in) begin
            w_entry.taken      = ex_branch_taken_in;
            w_entry.mispredict = ex_branch_mispredict_in;
            w_entry.npc        = ex_NPC_in;
        end
    end

    assign w_push = (ex_branch_inst_in || ex_store_inst_in) && !rob_flush_in;
    assign w_pop  = cmpl_valid_out && rob_cmpl_ready_in;

    cmpl_fifo #(
        .DEPTH (CQ_DEPTH)
    ) u_cmpl_fifo (
        .i_clk   (clock),
        .i_reset (reset),
        .i_push  (w_push),
        .i_pop   (w_pop),
        .i_flush (rob_flush_in),
        .i_data  (w_entry),
        .o_head  (w_head),
        .o_count (w_count),
        .o_empty (w_empty),
        .o_full  (w_full)
    );

    // PRF write / CDB register; a flush injects the null tag in place of EX's winner.
    always_ff @(posedge clock) begin
        if (reset || rob_flush_in) begin
            r_tag    <= PRF_W'(NULL_PRF);
            r_result <= '0;
        end else begin
            r_tag    <= ex_CDB_tag_in;
            r_result <= ex_result_in;
        end
    end

    // Sticky overflow: a push into a full queue that is not draining this cycle is lost.
    always_ff @(posedge clock) begin
        if (reset) begin
            r_overflow <= 1'b0;
        end else if (w_push && w_full && !w_pop) begin
            r_overflow <= 1'b1;
        end
    end

    assign ex_wb_PRF_num_out = r_tag;
    assign ex_wb_result_out  = r_result;
    assign cdb_valid_out     = (r_tag != PRF_W'(NULL_PRF));

    // Head fields read as zero whenever nothing is queued.
    assign cmpl_valid_out      = !w_empty;
    assign w_head_vis          = w_empty ? '0 : w_head;
    assign cmpl_ROB_num_out    = ROB_W'(w_head_vis.rob_num);
    assign cmpl_branch_out     = w_head_vis.branch;
    assign cmpl_store_out      = w_head_vis.store;
    assign cmpl_taken_out      = w_head_vis.taken;
    assign cmpl_mispredict_out = w_head_vis.mispredict;
    assign cmpl_NPC_out        = w_head_vis.npc;

    // Hold off issue one slot early so the branch/store already in EX still fits.
    assign cq_stall_out    = (w_count >= CNT_W'(CQ_DEPTH - 1));
    assign cq_overflow_out = r_overflow;

endmodule

// File: tb/tb_ex_complete_stage.sv
// Self-checking bench for ex_complete_stage: directed scenarios plus a randomized
// run against a queue-based reference model.
module tb_ex_complete_stage;
    import ex_complete_stage_pkg::*;

    localparam int DEPTH = CQ_DEPTH_DEF;

    logic                 clock;
    logic                 reset;
    logic [PRF_WIDTH-1:0] tag_in;
    logic [63:0]          result_in;
    logic                 br_in, tk_in, mp_in, st_in;
    logic [ROB_WIDTH-1:0] rob_in;
    logic [63:0]          npc_in;
    logic                 flush_in, ready_in;

    logic [PRF_WIDTH-1:0] wb_num;
    logic [63:0]          wb_res;
    logic                 cdb_v, c_valid, c_br, c_st, c_tk, c_mp, stall, ovf;
    logic [ROB_WIDTH-1:0] c_rob;
    logic [63:0]          c_npc;

    int n_cmp  = 0;
    int n_fail = 0;

    typedef struct {
        int          rob;
        bit          br, st, tk, mp;
        logic [63:0] npc;
    } exp_t;

    exp_t m_q[$];

    ex_complete_stage dut (
        .clock                   (clock),
        .reset                   (reset),
        .ex_CDB_tag_in           (tag_in),
        .ex_result_in            (result_in),
        .ex_branch_inst_in       (br_in),
        .ex_branch_taken_in      (tk_in),
        .ex_branch_mispredict_in (mp_in),
        .ex_store_inst_in        (st_in),
        .ex_ROB_number_in        (rob_in),
        .ex_NPC_in               (npc_in),
        .rob_flush_in            (flush_in),
        .rob_cmpl_ready_in       (ready_in),
        .ex_wb_PRF_num_out       (wb_num),
        .ex_wb_result_out        (wb_res),
        .cdb_valid_out           (cdb_v),
        .cmpl_valid_out          (c_valid),
        .cmpl_ROB_num_out        (c_rob),
        .cmpl_branch_out         (c_br),
        .cmpl_store_out          (c_st),
        .cmpl_taken_out          (c_tk),
        .cmpl_mispredict_out     (c_mp),
        .cmpl_NPC_out            (c_npc),
        .cq_stall_out            (stall),
        .cq_overflow_out         (ovf)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic idle();
        reset = 0; tag_in = '0; result_in = '0; br_in = 0; tk_in = 0; mp_in = 0;
        st_in = 0; rob_in = '0; npc_in = '0; flush_in = 0; ready_in = 0;
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic push_store(input int rob);
        idle();
        st_in = 1; rob_in = ROB_WIDTH'(rob); tk_in = 1; mp_in = 1; npc_in = 64'hDEAD_BEEF;
        tick();
    endtask

    task automatic test_reset();
        idle();
        reset = 1; tag_in = 6'd9; result_in = 64'h55; br_in = 1; rob_in = 5'd2;
        tick(); tick();
        n_cmp++; if (wb_num !== '0)  begin n_fail++; $display("FAIL reset_wb_num: got %0h want 0", wb_num); end
        n_cmp++; if (wb_res !== '0)  begin n_fail++; $display("FAIL reset_wb_res: got %0h want 0", wb_res); end
        n_cmp++; if (cdb_v !== 1'b0) begin n_fail++; $display("FAIL reset_cdb: got %0b want 0", cdb_v); end
        n_cmp++; if (c_valid !== 1'b0 || c_rob !== '0 || c_npc !== '0) begin n_fail++; $display("FAIL reset_cmpl: valid %0b rob %0h npc %0h want 0", c_valid, c_rob, c_npc); end
        n_cmp++; if (stall !== 1'b0 || ovf !== 1'b0) begin n_fail++; $display("FAIL reset_flags: stall %0b ovf %0b want 0 0", stall, ovf); end
        idle();
    endtask

    task automatic test_result_reg();
        idle(); tag_in = 6'd5; result_in = 64'h1234;
        tick();
        idle();
        n_cmp++; if (wb_num !== 6'd5)     begin n_fail++; $display("FAIL wb_num: got %0h want 5", wb_num); end
        n_cmp++; if (wb_res !== 64'h1234) begin n_fail++; $display("FAIL wb_res: got %0h want 1234", wb_res); end
        n_cmp++; if (cdb_v !== 1'b1)      begin n_fail++; $display("FAIL cdb_valid: got %0b want 1", cdb_v); end
        tick();
        n_cmp++; if (cdb_v !== 1'b0 || wb_num !== '0) begin n_fail++; $display("FAIL cdb_null: cdb %0b num %0h want 0 0", cdb_v, wb_num); end
    endtask

    task automatic test_branch_cmpl();
        idle();
        br_in = 1; rob_in = 5'd3; tk_in = 1; mp_in = 1; npc_in = 64'h400; ready_in = 1;
        tick();
        idle(); ready_in = 1;
        n_cmp++; if (c_valid !== 1'b1) begin n_fail++; $display("FAIL br_valid: got %0b want 1", c_valid); end
        n_cmp++; if (c_rob !== 5'd3)   begin n_fail++; $display("FAIL br_rob: got %0h want 3", c_rob); end
        n_cmp++; if ({c_br, c_st, c_tk, c_mp} !== 4'b1011) begin n_fail++; $display("FAIL br_flags: got %b want 1011", {c_br, c_st, c_tk, c_mp}); end
        n_cmp++; if (c_npc !== 64'h400) begin n_fail++; $display("FAIL br_npc: got %0h want 400", c_npc); end
        tick();
        n_cmp++; if (c_valid !== 1'b0 || c_rob !== '0 || c_npc !== '0 || c_br !== 1'b0) begin n_fail++; $display("FAIL br_popped: valid %0b rob %0h npc %0h br %0b want 0", c_valid, c_rob, c_npc, c_br); end
        idle();
    endtask

    task automatic test_fill_overflow();
        for (int k = 1; k <= 5; k++) begin
            push_store(k);
            n_cmp++; if (stall !== (k >= 3)) begin n_fail++; $display("FAIL fill_stall_%0d: got %0b want %0b", k, stall, k >= 3); end
            n_cmp++; if (ovf !== (k >= 5))   begin n_fail++; $display("FAIL fill_ovf_%0d: got %0b want %0b", k, ovf, k >= 5); end
        end
        idle();
        n_cmp++; if (c_rob !== 5'd1) begin n_fail++; $display("FAIL ovf_head: got %0h want 1", c_rob); end
        ready_in = 1;
        for (int k = 1; k <= 4; k++) begin
            n_cmp++;
            if (c_valid !== 1'b1 || c_rob !== ROB_WIDTH'(k) || c_st !== 1'b1 || c_br !== 1'b0 || c_tk !== 1'b0 || c_mp !== 1'b0 || c_npc !== '0) begin
                n_fail++; $display("FAIL drain_%0d: valid %0b rob %0h st %0b tk %0b mp %0b npc %0h", k, c_valid, c_rob, c_st, c_tk, c_mp, c_npc);
            end
            tick();
        end
        n_cmp++; if (c_valid !== 1'b0 || ovf !== 1'b1) begin n_fail++; $display("FAIL drained: valid %0b ovf %0b want 0 1", c_valid, ovf); end
        idle();
    endtask

    task automatic test_back_to_back();
        int exp_order[4] = '{2, 3, 4, 9};
        for (int k = 1; k <= 4; k++) push_store(k);
        idle(); st_in = 1; rob_in = 5'd9; ready_in = 1;
        tick();
        idle(); ready_in = 1;
        n_cmp++; if (stall !== 1'b1 || c_rob !== 5'd2) begin n_fail++; $display("FAIL b2b_full: stall %0b head %0h want 1 2", stall, c_rob); end
        for (int k = 0; k < 4; k++) begin
            n_cmp++; if (c_valid !== 1'b1 || c_rob !== ROB_WIDTH'(exp_order[k])) begin n_fail++; $display("FAIL b2b_drain_%0d: valid %0b rob %0h want %0h", k, c_valid, c_rob, exp_order[k]); end
            tick();
        end
        n_cmp++; if (c_valid !== 1'b0 || stall !== 1'b0) begin n_fail++; $display("FAIL b2b_empty: valid %0b stall %0b want 0 0", c_valid, stall); end
        idle();
    endtask

    task automatic test_flush();
        push_store(6);
        push_store(7);
        idle();
        tag_in = 6'd7; result_in = 64'hABCD; flush_in = 1; br_in = 1; rob_in = 5'd8; ready_in = 1;
        tick();
        idle();
        n_cmp++; if (c_valid !== 1'b0 || stall !== 1'b0) begin n_fail++; $display("FAIL flush_q: valid %0b stall %0b want 0 0", c_valid, stall); end
        n_cmp++; if (wb_num !== '0 || wb_res !== '0 || cdb_v !== 1'b0) begin n_fail++; $display("FAIL flush_wb: num %0h res %0h cdb %0b want 0", wb_num, wb_res, cdb_v); end
        tick();
        n_cmp++; if (c_valid !== 1'b0) begin n_fail++; $display("FAIL flush_push_dropped: valid %0b want 0", c_valid); end
    endtask

    task automatic test_reset_midop();
        for (int k = 10; k <= 12; k++) push_store(k);
        idle();
        n_cmp++; if (stall !== 1'b1 || ovf !== 1'b1 || c_rob !== 5'd10) begin n_fail++; $display("FAIL pre_reset: stall %0b ovf %0b head %0h want 1 1 a", stall, ovf, c_rob); end
        reset = 1; tag_in = 6'd3; result_in = 64'h77; st_in = 1; rob_in = 5'd13;
        tick();
        n_cmp++;
        if (wb_num !== '0 || wb_res !== '0 || cdb_v || c_valid || c_rob !== '0 || c_br || c_st || c_tk || c_mp || c_npc !== '0 || stall || ovf) begin
            n_fail++; $display("FAIL midop_reset: num %0h valid %0b rob %0h stall %0b ovf %0b want all 0", wb_num, c_valid, c_rob, stall, ovf);
        end
        idle();
        tick();
        n_cmp++; if (c_valid !== 1'b0 || ovf !== 1'b0) begin n_fail++; $display("FAIL post_reset: valid %0b ovf %0b want 0 0", c_valid, ovf); end
    endtask

    task automatic test_random();
        logic [PRF_WIDTH-1:0] m_tag;
        logic [63:0]          m_res;
        bit                   m_ovf, pop, push;
        exp_t                 e, h;
        int                   errs;
        m_q.delete(); m_tag = '0; m_res = '0; m_ovf = 0;
        idle(); reset = 1; tick(); idle();
        for (int i = 0; i < 600; i++) begin
            reset     = ($urandom_range(0, 99) == 0);
            flush_in  = ($urandom_range(0, 24) == 0);
            tag_in    = PRF_WIDTH'($urandom);
            result_in = {$urandom, $urandom};
            br_in     = ($urandom_range(0, 2) == 0);
            st_in     = ($urandom_range(0, 2) == 0);
            tk_in     = 1'($urandom);
            mp_in     = 1'($urandom);
            rob_in    = ROB_WIDTH'($urandom);
            npc_in    = {$urandom, $urandom};
            ready_in  = ($urandom_range(0, 2) == 0);
            pop  = (m_q.size() != 0) && ready_in;
            push = (br_in || st_in) && !flush_in;
            e.rob = int'(rob_in); e.br = br_in; e.st = st_in && !br_in;
            e.tk  = br_in && tk_in; e.mp = br_in && mp_in; e.npc = br_in ? npc_in : 64'd0;
            if (reset) begin
                m_q.delete(); m_ovf = 0; m_tag = '0; m_res = '0;
            end else if (flush_in) begin
                m_q.delete(); m_tag = '0; m_res = '0;
            end else begin
                m_tag = tag_in; m_res = result_in;
                if (pop) void'(m_q.pop_front());
                if (push) begin
                    if (m_q.size() < DEPTH) m_q.push_back(e);
                    else m_ovf = 1;
                end
            end
            tick();
            if (m_q.size() != 0) h = m_q[0];
            else begin h.rob = 0; h.br = 0; h.st = 0; h.tk = 0; h.mp = 0; h.npc = '0; end
            errs = 0;
            n_cmp++;
            if (wb_num !== m_tag || wb_res !== m_res || cdb_v !== (m_tag != 0)) errs++;
            if (c_valid !== (m_q.size() != 0) || c_rob !== ROB_WIDTH'(h.rob)) errs++;
            if ({c_br, c_st, c_tk, c_mp} !== {h.br, h.st, h.tk, h.mp} || c_npc !== h.npc) errs++;
            if (stall !== (m_q.size() >= DEPTH - 1) || ovf !== m_ovf) errs++;
            if (errs != 0) begin
                n_fail++;
                $display("FAIL rand_%0d: num %0h/%0h valid %0b/%0b rob %0h/%0h npc %0h/%0h stall %0b ovf %0b/%0b (got/want)",
                         i, wb_num, m_tag, c_valid, m_q.size() != 0, c_rob, h.rob, c_npc, h.npc, stall, ovf, m_ovf);
            end
        end
        idle();
    endtask

    initial begin
        idle();
        test_reset();
        test_result_reg();
        test_branch_cmpl();
        test_fill_overflow();
        test_back_to_back();
        test_flush();
        test_reset_midop();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
